game_referee: RTL

Turn sequencer and referee for the two-player fighting game. It collects one action per player per turn over a valid/ready handshake and substitutes `await` when a player times out. It then drives the players' `actionEnable` and `isGameOver` inputs, reads back both health values, and declares the winner on knockout or turn limit. It sits between the input decoders and the `firstPlayer`/second-player modules.

---
 rtl/game_pkg.sv | 34 +++
 rtl/turn_timeout_counter.sv | 25 ++
 rtl/game_referee.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared codes for the fighting-game referee: action encodings, winner codes,
// referee FSM state constants and the health ceiling.
package game_pkg;

  typedef enum logic [2:0] {
    ACT_KICK   = 3'b000,
    ACT_PUNCH  = 3'b001,
    ACT_AWAIT  = 3'b010,
    ACT_JUMP   = 3'b011,
    ACT_LEFT1  = 3'b100,
    ACT_LEFT2  = 3'b101,
    ACT_RIGHT1 = 3'b110,
    ACT_RIGHT2 = 3'b111
  } action_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Referee states kept as plain constants so legacy decoders can share them.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_APPLY   = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_OVER    = 3'd6;

  localparam logic [1:0] HEALTH_MAX = 2'b11;

endpackage

// File: rtl/turn_timeout_counter.sv
// Counts cycles spent collecting actions; expired flags the last allowed cycle.
module turn_timeout_counter #(
  parameter int TURN_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  // Saturates at the last cycle so a stalled enable never wraps back to zero.
  always_ff @(posedge clk) begin
    if (!reset)                 count_q <= '0;
    else if (clear)             count_q <= '0;
    else if (enable && !expired) count_q <= count_q + 1'b1;
  end

  assign expired = (count_q == CW'(TURN_TIMEOUT - 1));

endmodule

// File: rtl/game_referee.sv
// Turn sequencer and referee: collects one action per player per turn, strobes
// the player modules, then judges knockout, underflow and the turn limit.
module game_referee
  import game_pkg::*;
#(
  parameter int TURN_TIMEOUT = 16,
  parameter int MAX_TURNS    = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           p1_valid,
  input  logic [2:0]                     p1_action,
  output logic                           p1_ready,
  input  logic                           p2_valid,
  input  logic [2:0]                     p2_action,
  output logic                           p2_ready,
  input  logic [1:0]                     health1,
  input  logic [1:0]                     health2,
  output logic [2:0]                     action1,
  output logic [2:0]                     action2,
  output logic                           actionEnable,
  output logic                           isGameOver,
  output logic                           player_reset,
  output logic [1:0]                     winner,
  output logic [$clog2(MAX_TURNS+1)-1:0] turn_count
);

  localparam int TCW = $clog2(MAX_TURNS + 1);

  logic [2:0]     state_q, state_d;
  logic           cap1_q, cap1_d, cap2_q, cap2_d;
  logic [2:0]     action1_q, action1_d, action2_q, action2_d;
  logic [1:0]     pre1_q, pre1_d, pre2_q, pre2_d;
  logic [1:0]     winner_q, winner_d;
  logic [TCW-1:0] turn_q, turn_d;
  logic           over_q, over_d;
  logic           enable_q, prst_q;
  logic           expired, take1, take2, ko1, ko2;

  assign p1_ready = (state_q == ST_COLLECT) && !cap1_q;
  assign p2_ready = (state_q == ST_COLLECT) && !cap2_q;
  assign take1    = p1_valid && p1_ready;
  assign take2    = p2_valid && p2_ready;

  turn_timeout_counter #(.TURN_TIMEOUT(TURN_TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_COLLECT),
    .enable  (state_q == ST_COLLECT),
    .expired (expired)
  );

  // Zero health, a +2 jump (wrapped subtraction) or any gain without await is a knockout.
  assign ko1 = (health1 == 2'd0) || ({1'b0, health1} == {1'b0, pre1_q} + 3'd2) ||
               ((health1 > pre1_q) && (action1_q != ACT_AWAIT));
  assign ko2 = (health2 == 2'd0) || ({1'b0, health2} == {1'b0, pre2_q} + 3'd2) ||
               ((health2 > pre2_q) && (action2_q != ACT_AWAIT));

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cap1_d    = cap1_q;
    cap2_d    = cap2_q;
    action1_d = action1_q;
    action2_d = action2_q;
    pre1_d    = pre1_q;
    pre2_d    = pre2_q;
    winner_d  = winner_q;
    turn_d    = turn_q;
    over_d    = over_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start) state_d = ST_INIT;
      ST_INIT: begin
        cap1_d   = 1'b0;
        cap2_d   = 1'b0;
        turn_d   = '0;
        winner_d = WIN_NONE;
        over_d   = 1'b0;
        state_d  = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (take1) begin
          action1_d = p1_action;
          cap1_d    = 1'b1;
        end
        if (take2) begin
          action2_d = p2_action;
          cap2_d    = 1'b1;
        end
        if (cap1_d && cap2_d) begin
          state_d = ST_APPLY;
        end else if (expired) begin
          if (!cap1_d) action1_d = ACT_AWAIT;
          if (!cap2_d) action2_d = ACT_AWAIT;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        pre1_d  = health1;
        pre2_d  = health2;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (ko1 && ko2)  winner_d = WIN_DRAW;
        else if (ko1)    winner_d = WIN_P2;
        else if (ko2)    winner_d = WIN_P1;
        else begin
          turn_d = turn_q + 1'b1;
          if (turn_d == TCW'(MAX_TURNS)) begin
            if (health1 > health2)      winner_d = WIN_P1;
            else if (health2 > health1) winner_d = WIN_P2;
            else                        winner_d = WIN_DRAW;
          end
        end
        if (winner_d != WIN_NONE) begin
          over_d  = 1'b1;
          state_d = ST_OVER;
        end else begin
          cap1_d  = 1'b0;
          cap2_d  = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cap1_q    <= 1'b0;
      cap2_q    <= 1'b0;
      action1_q <= 3'b000;
      action2_q <= 3'b000;
      pre1_q    <= 2'b00;
      pre2_q    <= 2'b00;
      winner_q  <= WIN_NONE;
      turn_q    <= '0;
      over_q    <= 1'b0;
      enable_q  <= 1'b0;
      prst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap1_q    <= cap1_d;
      cap2_q    <= cap2_d;
      action1_q <= action1_d;
      action2_q <= action2_d;
      pre1_q    <= pre1_d;
      pre2_q    <= pre2_d;
      winner_q  <= winner_d;
      turn_q    <= turn_d;
      over_q    <= over_d;
      enable_q  <= (state_d == ST_APPLY);
      prst_q    <= (state_d != ST_INIT);
    end
  end

  assign action1      = action1_q;
  assign action2      = action2_q;
  assign actionEnable = enable_q;
  assign isGameOver   = over_q;
  assign player_reset = prst_q;
  assign winner       = winner_q;
  assign turn_count   = turn_q;

endmodule
